// File: rtl/instr_sequencer.sv
// Program store and instruction issue for the 16-bit processor's din port.
// Presents one word at a time and advances only on the processor's ir_ack/instr_done handshakes.
module instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic [AW:0]      prog_len,
    input  logic             start,
    input  logic             abort,
    input  logic             ir_ack,
    input  logic             instr_done,
    output logic [WIDTH-1:0] din,
    output logic             tick_ena,
    output logic [AW:0]      pc,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_IMM   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [AW:0] PC_ONE = (AW+1)'(1);
    localparam logic [AW:0] PC_TWO = (AW+1)'(2);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [AW:0]      len;
    logic [AW:0]      len_nxt;
    logic [AW:0]      pc_nxt;
    logic [AW:0]      fetch_pc;
    logic [WIDTH-1:0] fetch_word;
    logic [WIDTH-1:0] din_nxt;
    logic             tick_nxt;
    logic             err_nxt;
    logic             at_rest;
    logic             wr_accept;
    logic             is_imm;
    logic             advance;

    assign at_rest   = (state == S_IDLE) || (state == S_HALT);
    assign wr_accept = load_en && !abort && at_rest;
    assign is_imm    = (din[WIDTH-1 -: 3] == 3'b010) || (din[WIDTH-1 -: 3] == 3'b111);

    // Only one address can ever be fetched from a given state; in ISSUE/WAIT/IMM it
    // is also the pc value after advancing, so it doubles as the new pc.
    always_comb begin
        fetch_pc = '0;
        case (state)
            S_ISSUE, S_WAIT: fetch_pc = pc + PC_ONE;
            S_IMM:           fetch_pc = pc + PC_TWO;
            default:         fetch_pc = '0;
        endcase
    end

    // Forward a same-cycle load so a start issued alongside a write fetches the new word.
    assign fetch_word = (wr_accept && (load_addr == fetch_pc[AW-1:0]))
                      ? load_data : mem[fetch_pc[AW-1:0]];

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        len_nxt   = len;
        din_nxt   = din;
        tick_nxt  = tick_ena;
        err_nxt   = err;
        advance   = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
            pc_nxt    = '0;
            din_nxt   = '0;
            tick_nxt  = 1'b0;
            err_nxt   = 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        len_nxt = prog_len;
                        pc_nxt  = '0;
                        err_nxt = 1'b0;
                        if (prog_len == '0) begin
                            state_nxt = S_HALT;
                            tick_nxt  = 1'b0;
                        end else begin
                            state_nxt = S_ISSUE;
                            din_nxt   = fetch_word;
                            tick_nxt  = 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (ir_ack) begin
                        if (is_imm) begin
                            if ((pc + PC_ONE < len) && !instr_done) begin
                                state_nxt = S_IMM;
                                din_nxt   = fetch_word;
                            end else begin
                                state_nxt = S_HALT;
                                tick_nxt  = 1'b0;
                                err_nxt   = 1'b1;
                            end
                        end else if (instr_done) begin
                            advance = 1'b1;
                        end else begin
                            state_nxt = S_WAIT;
                        end
                    end
                end
                S_IMM, S_WAIT: begin
                    if (instr_done) begin
                        advance = 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    tick_nxt  = 1'b0;
                end
            endcase

            if (advance) begin
                pc_nxt = fetch_pc;
                if (fetch_pc >= len) begin
                    state_nxt = S_HALT;
                    tick_nxt  = 1'b0;
                end else begin
                    state_nxt = S_ISSUE;
                    din_nxt   = fetch_word;
                    tick_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            pc       <= '0;
            len      <= '0;
            din      <= '0;
            tick_ena <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            len      <= len_nxt;
            din      <= din_nxt;
            tick_ena <= tick_nxt;
            busy     <= (state_nxt == S_ISSUE) || (state_nxt == S_IMM) || (state_nxt == S_WAIT);
            done     <= (state_nxt == S_HALT);
            err      <= err_nxt;
        end
    end

    // Program memory survives reset so a reset mid-run can restart the same program.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[load_addr] <= load_data;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed scoreboard bench for instr_sequencer: expected outputs are queued with each
// stimulus step and popped for comparison one cycle later.
module tb_instr_sequencer;

    logic       clk;
    logic       rst;
    logic       load_en;
    logic [3:0] load_addr;
    logic [8:0] load_data;
    logic [4:0] prog_len;
    logic       start;
    logic       abort;
    logic       ir_ack;
    logic       instr_done;
    logic [8:0] din;
    logic       tick_ena;
    logic [4:0] pc;
    logic       busy;
    logic       done;
    logic       err;

    typedef struct {
        string       tag;
        logic [17:0] vec;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    instr_sequencer #(.DEPTH(16), .WIDTH(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .prog_len   (prog_len),
        .start      (start),
        .abort      (abort),
        .ir_ack     (ir_ack),
        .instr_done (instr_done),
        .din        (din),
        .tick_ena   (tick_ena),
        .pc         (pc),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [17:0] pack(input logic [8:0] d, input logic [4:0] p,
                                         input logic t, input logic b,
                                         input logic dn, input logic e);
        return {d, p, t, b, dn, e};
    endfunction

    task automatic pushExpect(input string tag, input logic [8:0] d, input logic [4:0] p,
                              input logic t, input logic b, input logic dn, input logic e);
        exp_t x;
        x.tag = tag;
        x.vec = pack(d, p, t, b, dn, e);
        sb.push_back(x);
    endtask

    task automatic checkOutput();
        exp_t        x;
        logic [17:0] obs;
        obs = pack(din, pc, tick_ena, busy, done, err);
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("[TB] FAIL scoreboard_empty: observed %h with no expectation", obs);
        end else begin
            x = sb.pop_front();
            assert (obs === x.vec) else begin
                miscompares++;
                $error("[TB] FAIL %s: observed din=%h pc=%0d tick=%b busy=%b done=%b err=%b, expected din=%h pc=%0d tick=%b busy=%b done=%b err=%b",
                       x.tag, obs[17:9], obs[8:4], obs[3], obs[2], obs[1], obs[0],
                       x.vec[17:9], x.vec[8:4], x.vec[3], x.vec[2], x.vec[1], x.vec[0]);
            end
        end
    endtask

    // One clock of whatever inputs are currently driven; pulses are dropped after the edge.
    task automatic applyStimulus(input string tag, input logic [8:0] d, input logic [4:0] p,
                                 input logic t, input logic b, input logic dn, input logic e);
        pushExpect(tag, d, p, t, b, dn, e);
        @(posedge clk);
        #1;
        load_en    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        ir_ack     = 1'b0;
        instr_done = 1'b0;
        checkOutput();
    endtask

    task automatic setLoad(input logic [3:0] a, input logic [8:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
    endtask

    task automatic setStart(input logic [4:0] len);
        start    = 1'b1;
        prog_len = len;
    endtask

    initial begin
        rst = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0; prog_len = '0;
        start = 1'b0; abort = 1'b0; ir_ack = 1'b0; instr_done = 1'b0;
        #3;
        pushExpect("reset", 9'h000, 5'd0, 0, 0, 0, 0);
        checkOutput();
        #9;
        rst = 1'b1;

        $display("[TB] two-word program");
        setLoad(4'd0, 9'o101);  applyStimulus("t1_load0", 9'h000, 5'd0, 0, 0, 0, 0);
        setLoad(4'd1, 9'o000);  applyStimulus("t1_load1", 9'h000, 5'd0, 0, 0, 0, 0);
        setStart(5'd2);         applyStimulus("t1_start", 9'o101, 5'd0, 1, 1, 0, 0);
        ir_ack = 1'b1;          applyStimulus("t1_ack0",  9'o101, 5'd0, 1, 1, 0, 0);
        instr_done = 1'b1;      applyStimulus("t1_done0", 9'o000, 5'd1, 1, 1, 0, 0);
        ir_ack = 1'b1;          applyStimulus("t1_ack1",  9'o000, 5'd1, 1, 1, 0, 0);
        instr_done = 1'b1;      applyStimulus("t1_halt",  9'o000, 5'd2, 0, 0, 1, 0);

        $display("[TB] MOV_IMM with load and start in the same cycle");
        setLoad(4'd1, 9'h005);  applyStimulus("t2_load1", 9'o000, 5'd2, 0, 0, 1, 0);
        setLoad(4'd2, 9'o000);  applyStimulus("t2_load2", 9'o000, 5'd2, 0, 0, 1, 0);
        setLoad(4'd0, 9'o700);
        setStart(5'd3);         applyStimulus("t2_start_bypass", 9'o700, 5'd0, 1, 1, 0, 0);
        ir_ack = 1'b1;          applyStimulus("t2_imm_word", 9'h005, 5'd0, 1, 1, 0, 0);
        instr_done = 1'b1;      applyStimulus("t2_pc_plus2", 9'o000, 5'd2, 1, 1, 0, 0);
        ir_ack = 1'b1;          applyStimulus("t2_ack2",  9'o000, 5'd2, 1, 1, 0, 0);
        instr_done = 1'b1;      applyStimulus("t2_halt",  9'o000, 5'd3, 0, 0, 1, 0);

        $display("[TB] truncated immediate");
        setLoad(4'd0, 9'o200);  applyStimulus("t3_load0", 9'o000, 5'd3, 0, 0, 1, 0);
        setStart(5'd1);         applyStimulus("t3_start", 9'o200, 5'd0, 1, 1, 0, 0);
        ir_ack = 1'b1;          applyStimulus("t3_err",   9'o200, 5'd0, 0, 0, 1, 1);
        setStart(5'd0);         applyStimulus("t3_err_clear", 9'o200, 5'd0, 0, 0, 1, 0);

        $display("[TB] abort in WAIT and blocked load");
        setLoad(4'd0, 9'o101);  applyStimulus("t4_load0", 9'o200, 5'd0, 0, 0, 1, 0);
        setStart(5'd2);         applyStimulus("t4_start", 9'o101, 5'd0, 1, 1, 0, 0);
        instr_done = 1'b1;      applyStimulus("t4_early_done", 9'o101, 5'd0, 1, 1, 0, 0);
        ir_ack = 1'b1;          applyStimulus("t4_ack0",  9'o101, 5'd0, 1, 1, 0, 0);
        instr_done = 1'b1;      applyStimulus("t4_done0", 9'h005, 5'd1, 1, 1, 0, 0);
        ir_ack = 1'b1;          applyStimulus("t4_ack1",  9'h005, 5'd1, 1, 1, 0, 0);
        setLoad(4'd1, 9'o777);  applyStimulus("t4_busy_load", 9'h005, 5'd1, 1, 1, 0, 0);
        abort = 1'b1;           applyStimulus("t4_abort", 9'h000, 5'd0, 0, 0, 0, 0);
        setStart(5'd2);         applyStimulus("t4_restart", 9'o101, 5'd0, 1, 1, 0, 0);
        ir_ack = 1'b1;
        instr_done = 1'b1;      applyStimulus("t4_readback", 9'h005, 5'd1, 1, 1, 0, 0);
        abort = 1'b1;           applyStimulus("t4_abort2", 9'h000, 5'd0, 0, 0, 0, 0);

        $display("[TB] empty program and full-depth program");
        setStart(5'd0);         applyStimulus("t5_len0", 9'h000, 5'd0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) begin
            setLoad(4'(i), 9'(i + 1));
            applyStimulus($sformatf("t5_load%0d", i), 9'h000, 5'd0, 0, 0, 1, 0);
        end
        setStart(5'd16);        applyStimulus("t5_start16", 9'd1, 5'd0, 1, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            ir_ack = 1'b1;
            instr_done = 1'b1;
            if (i < 15)
                applyStimulus($sformatf("t5_step%0d", i), 9'(i + 2), 5'(i + 1), 1, 1, 0, 0);
            else
                applyStimulus("t5_pc16_halt", 9'd16, 5'd16, 0, 0, 1, 0);
        end

        $display("[TB] async reset during IMM");
        setLoad(4'd0, 9'o700);  applyStimulus("t6_load0", 9'd16, 5'd16, 0, 0, 1, 0);
        setLoad(4'd1, 9'h00A);  applyStimulus("t6_load1", 9'd16, 5'd16, 0, 0, 1, 0);
        setStart(5'd3);         applyStimulus("t6_start", 9'o700, 5'd0, 1, 1, 0, 0);
        ir_ack = 1'b1;          applyStimulus("t6_imm",   9'h00A, 5'd0, 1, 1, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        pushExpect("t6_async_reset", 9'h000, 5'd0, 0, 0, 0, 0);
        checkOutput();
        #1;
        rst = 1'b1;
        setStart(5'd3);         applyStimulus("t6_restart", 9'o700, 5'd0, 1, 1, 0, 0);
        ir_ack = 1'b1;          applyStimulus("t6_imm_kept", 9'h00A, 5'd0, 1, 1, 0, 0);
        instr_done = 1'b1;      applyStimulus("t6_pc2", 9'd3, 5'd2, 1, 1, 0, 0);
        ir_ack = 1'b1;          applyStimulus("t6_ack2", 9'd3, 5'd2, 1, 1, 0, 0);
        instr_done = 1'b1;      applyStimulus("t6_halt", 9'd3, 5'd3, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
